// File: rtl/ibex_rf_ctx_ctrl.sv
// ibex_rf_ctx_ctrl
// Register-file context controller. Owns the active register bank index,
// accepts context-switch requests, drains in-flight writebacks, and can copy
// x1..xLast from the active bank into the target bank by borrowing register
// file port A (read address, write port). Outside a switch, core port A
// traffic passes straight through to the register file.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   switch_req_i                  switch request, held until switch_done_o
//   switch_ctx_i                  target bank, sampled on accept
//   switch_copy_i                 copy active bank into target, sampled on accept
//   wb_pending_i                  core has a register write in flight
//   switch_done_o                 one-cycle completion pulse
//   switch_err_o                  with done: target out of range, bank unchanged
//   stall_o                       core must not issue while a switch is running
//   ctx_o                         active bank
//   core_raddr_a_i .. core_we_a_i core port A read address and write port
//   rf_raddr_a_o .. rf_we_a_o     port A toward the register file
//   rf_rdata_a_i                  register file port A read data (copy source)
//   rf_rsel_o, rf_wsel_o          bank selects for reads and writes
module ibex_rf_ctx_ctrl #(
  parameter int unsigned NumRegFiles = 4,
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = 32,
  localparam int unsigned CtxW       = (NumRegFiles > 1) ? $clog2(NumRegFiles) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 switch_req_i,
  input  logic [CtxW-1:0]      switch_ctx_i,
  input  logic                 switch_copy_i,
  input  logic                 wb_pending_i,
  output logic                 switch_done_o,
  output logic                 switch_err_o,
  output logic                 stall_o,
  output logic [CtxW-1:0]      ctx_o,
  input  logic [4:0]           core_raddr_a_i,
  input  logic [4:0]           core_waddr_a_i,
  input  logic [DataWidth-1:0] core_wdata_a_i,
  input  logic                 core_we_a_i,
  output logic [4:0]           rf_raddr_a_o,
  output logic [4:0]           rf_waddr_a_o,
  output logic [DataWidth-1:0] rf_wdata_a_o,
  output logic                 rf_we_a_o,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  output logic [CtxW-1:0]      rf_rsel_o,
  output logic [CtxW-1:0]      rf_wsel_o
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COPY,
    COMMIT
  } state_e;

  localparam logic [4:0]    LastReg    = RV32E ? 5'd15 : 5'd31;
  // Bank count widened by one bit so a target equal to NumRegFiles is
  // representable when NumRegFiles is a power of two.
  localparam logic [CtxW:0] NumRegsExt = (CtxW + 1)'(NumRegFiles);

  state_e          state_q, state_d;
  logic [CtxW-1:0] ctx_q;
  logic [CtxW-1:0] tgt_q;
  logic            copy_q;
  logic [4:0]      cnt_q;
  logic            drain_ok;
  logic            tgt_bad;

  function automatic logic out_of_range(input logic [CtxW-1:0] c);
    return {1'b0, c} >= NumRegsExt;
  endfunction

  // Writes already issued by the core must land in the current bank before
  // anything is copied or the bank index moves.
  assign drain_ok = !wb_pending_i && !core_we_a_i;
  assign tgt_bad  = out_of_range(tgt_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_q  <= '0;
      tgt_q  <= '0;
      copy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (switch_req_i) begin
            tgt_q  <= switch_ctx_i;
            // Copying onto itself or into a non-existent bank is pointless.
            copy_q <= switch_copy_i && (switch_ctx_i != ctx_q) && !out_of_range(switch_ctx_i);
          end
        end
        DRAIN: begin
          if (drain_ok) cnt_q <= 5'd1;  // x0 is hardwired, start at x1
        end
        COPY: begin
          cnt_q <= cnt_q + 5'd1;
        end
        COMMIT: begin
          if (!tgt_bad) ctx_q <= tgt_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (switch_req_i) state_d = DRAIN;
      DRAIN:   if (drain_ok) state_d = copy_q ? COPY : COMMIT;
      COPY:    if (cnt_q == LastReg) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_raddr_a_o  = core_raddr_a_i;
    rf_waddr_a_o  = core_waddr_a_i;
    rf_wdata_a_o  = core_wdata_a_i;
    rf_we_a_o     = core_we_a_i;
    rf_rsel_o     = ctx_q;
    rf_wsel_o     = ctx_q;
    switch_done_o = 1'b0;
    switch_err_o  = 1'b0;
    stall_o       = (state_q != IDLE);
    unique case (state_q)
      COPY: begin
        // Read xN from the active bank and write the same index of the target
        // bank in one cycle; the register file read is combinational.
        rf_raddr_a_o = cnt_q;
        rf_waddr_a_o = cnt_q;
        rf_wdata_a_o = rf_rdata_a_i;
        rf_we_a_o    = 1'b1;
        rf_wsel_o    = tgt_q;
      end
      COMMIT: begin
        rf_we_a_o     = 1'b0;
        switch_done_o = 1'b1;
        switch_err_o  = tgt_bad;
      end
      default: ;
    endcase
  end

  assign ctx_o = ctx_q;

endmodule

// File: tb/tb_ibex_rf_ctx_ctrl.sv
module tb_ibex_rf_ctx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [1:0]  sw_ctx;
  logic        sw_copy;
  logic        wb_pending;
  logic        done, err, stall;
  logic [1:0]  ctx;
  logic [4:0]  core_raddr, core_waddr;
  logic [31:0] core_wdata;
  logic        core_we;
  logic [4:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [31:0] rf_rdata;
  logic [1:0]  rf_rsel, rf_wsel;

  // Second instance with a non-power-of-two bank count (out-of-range targets).
  logic        req3;
  logic [1:0]  sw_ctx3;
  logic        sw_copy3;
  logic        done3, err3, stall3;
  logic [1:0]  ctx3;
  logic [4:0]  rf_raddr3, rf_waddr3;
  logic [31:0] rf_wdata3;
  logic        rf_we3;
  logic [1:0]  rf_rsel3, rf_wsel3;
  logic        zero1;
  logic [4:0]  zero5;
  logic [31:0] zero32;

  int checks = 0;
  int errors = 0;

  // Register file environment (written only by the DUT through tick) and the
  // reference model of the expected bank contents.
  logic [31:0] rf      [4][32];
  logic [31:0] ref_bank[4][32];
  logic [1:0]  exp_ctx;

  ibex_rf_ctx_ctrl #(.NumRegFiles(4), .RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .switch_req_i(req), .switch_ctx_i(sw_ctx), .switch_copy_i(sw_copy),
    .wb_pending_i(wb_pending),
    .switch_done_o(done), .switch_err_o(err), .stall_o(stall), .ctx_o(ctx),
    .core_raddr_a_i(core_raddr), .core_waddr_a_i(core_waddr),
    .core_wdata_a_i(core_wdata), .core_we_a_i(core_we),
    .rf_raddr_a_o(rf_raddr), .rf_waddr_a_o(rf_waddr), .rf_wdata_a_o(rf_wdata),
    .rf_we_a_o(rf_we), .rf_rdata_a_i(rf_rdata),
    .rf_rsel_o(rf_rsel), .rf_wsel_o(rf_wsel)
  );

  ibex_rf_ctx_ctrl #(.NumRegFiles(3), .RV32E(1'b0), .DataWidth(32)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .switch_req_i(req3), .switch_ctx_i(sw_ctx3), .switch_copy_i(sw_copy3),
    .wb_pending_i(zero1),
    .switch_done_o(done3), .switch_err_o(err3), .stall_o(stall3), .ctx_o(ctx3),
    .core_raddr_a_i(zero5), .core_waddr_a_i(zero5),
    .core_wdata_a_i(zero32), .core_we_a_i(zero1),
    .rf_raddr_a_o(rf_raddr3), .rf_waddr_a_o(rf_waddr3), .rf_wdata_a_o(rf_wdata3),
    .rf_we_a_o(rf_we3), .rf_rdata_a_i(zero32),
    .rf_rsel_o(rf_rsel3), .rf_wsel_o(rf_wsel3)
  );

  assign rf_rdata = (rf_raddr == 5'd0) ? 32'h0 : rf[rf_rsel][rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle: capture the port A write just before the edge and
  // apply it to the register file model, then return 1 time unit after it.
  task automatic tick();
    logic cw; logic [1:0] cb; logic [4:0] ca; logic [31:0] cd;
    #2;
    cw = rf_we && rst_n; cb = rf_wsel; ca = rf_waddr; cd = rf_wdata;
    @(posedge clk);
    if (cw && ca != 5'd0) rf[cb][ca] = cd;
    #1;
  endtask

  function automatic int bank_diffs();
    int n = 0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 32; i++)
        if (rf[b][i] !== ref_bank[b][i]) n++;
    return n;
  endfunction

  // Run one switch on the main instance. Returns the done cycle (accept = 0,
  // -1 on timeout), number of block-issued writes and protocol violations.
  task automatic do_switch(input logic [1:0] t, input logic cp, input int pend,
                           input int wr_cyc, input logic [4:0] wr_addr,
                           input logic [31:0] wr_data,
                           output int lat, output int nwr, output int bad);
    int cyc;
    logic [1:0] c0;
    c0 = exp_ctx; lat = -1; nwr = 0; bad = 0; cyc = 0;
    req = 1'b1; sw_ctx = t; sw_copy = cp; wb_pending = 1'b0; core_we = 1'b0;
    #1;
    if (stall !== 1'b0) bad++;
    while (lat < 0 && cyc < 200) begin
      tick();
      cyc++;
      wb_pending = (cyc <= pend);
      core_we    = (cyc == wr_cyc);
      core_waddr = wr_addr;
      core_wdata = wr_data;
      #1;
      if (stall !== 1'b1) bad++;
      if (rf_we && !core_we) begin
        nwr++;
        if (rf_waddr !== 5'(nwr) || rf_raddr !== 5'(nwr) || rf_rsel !== c0 || rf_wsel !== t) bad++;
      end
      if (core_we && (rf_we !== 1'b1 || rf_wsel !== c0 || rf_waddr !== wr_addr || rf_wdata !== wr_data)) bad++;
      if (done) lat = cyc;
    end
    req = 1'b0; sw_copy = 1'b0; wb_pending = 1'b0; core_we = 1'b0;
  endtask

  task automatic do_switch3(input logic [1:0] t, input logic cp,
                            output int lat, output logic e, output int nwr);
    int cyc;
    lat = -1; nwr = 0; e = 1'b0; cyc = 0;
    req3 = 1'b1; sw_ctx3 = t; sw_copy3 = cp;
    while (lat < 0 && cyc < 100) begin
      tick();
      cyc++;
      #1;
      if (rf_we3) nwr++;
      if (done3) begin lat = cyc; e = err3; end
    end
    req3 = 1'b0; sw_copy3 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ctx !== 2'd0) begin errors++; $display("FAIL reset_ctx: got %0d want 0", ctx); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
    checks++; if (rf_rsel !== 2'd0 || rf_wsel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d/%0d want 0/0", rf_rsel, rf_wsel); end
    rst_n = 1'b1;
    exp_ctx = 2'd0;
  endtask

  task automatic test_passthrough();
    core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hDEAD; core_raddr = 5'd9;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD || rf_wsel !== 2'd0 || stall !== 1'b0 || rf_raddr !== 5'd9)
      begin errors++; $display("FAIL pass_basic: got we=%b wa=%0d wd=%h wsel=%0d stall=%b ra=%0d want 1/5/dead/0/0/9",
                              rf_we, rf_waddr, rf_wdata, rf_wsel, stall, rf_raddr); end
    tick();
    ref_bank[0][5] = 32'hDEAD;
    for (int k = 0; k < 4; k++) begin
      logic        we;
      logic [4:0]  wa, ra;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(1, 31));
      ra = 5'($urandom); wd = $urandom;
      core_we = we; core_waddr = wa; core_wdata = wd; core_raddr = ra;
      #1;
      checks++;
      if (rf_we !== we || rf_waddr !== wa || rf_wdata !== wd || rf_raddr !== ra || rf_rsel !== 2'd0 || rf_wsel !== 2'd0)
        begin errors++; $display("FAIL pass_rand%0d: got we=%b wa=%0d wd=%h ra=%0d want %b/%0d/%h/%0d", k,
                                rf_we, rf_waddr, rf_wdata, rf_raddr, we, wa, wd, ra); end
      tick();
      if (we) ref_bank[0][wa] = wd;
    end
    core_we = 1'b0;
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL pass_banks: got %0d diffs want 0", bank_diffs()); end
  endtask

  task automatic test_drain();
    int lat, nwr, bad;
    logic [31:0] d;
    d = $urandom;
    // Pending writeback for 3 cycles; core write in the middle lands in bank 0.
    do_switch(2'd3, 1'b0, 3, 2, 5'd7, d, lat, nwr, bad);
    ref_bank[0][7] = d;
    exp_ctx = 2'd3;
    checks++; if (lat != 5) begin errors++; $display("FAIL drain_latency: got %0d want 5", lat); end
    checks++; if (nwr != 0 || bad != 0) begin errors++; $display("FAIL drain_traffic: got writes=%0d bad=%0d want 0/0", nwr, bad); end
    tick();
    checks++; if (ctx !== 2'd3 || stall !== 1'b0) begin errors++; $display("FAIL drain_ctx: got ctx=%0d stall=%b want 3/0", ctx, stall); end
    checks++; if (rf[0][7] !== d) begin errors++; $display("FAIL drain_core_wr: got %h want %h", rf[0][7], d); end
  endtask

  task automatic test_switch_nocopy();
    int lat, nwr, bad;
    do_switch(2'd2, 1'b0, 0, 0, 5'd0, 32'h0, lat, nwr, bad);
    exp_ctx = 2'd2;
    checks++; if (lat != 2) begin errors++; $display("FAIL nocopy_latency: got %0d want 2", lat); end
    checks++; if (nwr != 0 || bad != 0) begin errors++; $display("FAIL nocopy_traffic: got writes=%0d bad=%0d want 0/0", nwr, bad); end
    tick();
    checks++; if (ctx !== 2'd2) begin errors++; $display("FAIL nocopy_ctx: got %0d want 2", ctx); end
    do_switch(2'd0, 1'b0, 0, 0, 5'd0, 32'h0, lat, nwr, bad);
    exp_ctx = 2'd0;
    tick();
    checks++; if (lat != 2 || ctx !== 2'd0) begin errors++; $display("FAIL nocopy_back: got lat=%0d ctx=%0d want 2/0", lat, ctx); end
  endtask

  task automatic test_copy();
    int lat, nwr, bad, wrong;
    for (int i = 1; i < 32; i++) begin
      rf[0][i] = 32'h100 + 32'(i);
      ref_bank[0][i] = 32'h100 + 32'(i);
    end
    do_switch(2'd1, 1'b1, 0, 0, 5'd0, 32'h0, lat, nwr, bad);
    for (int i = 1; i < 32; i++) ref_bank[1][i] = ref_bank[0][i];
    exp_ctx = 2'd1;
    checks++; if (lat != 33) begin errors++; $display("FAIL copy_latency: got %0d want 33", lat); end
    checks++; if (nwr != 31 || bad != 0) begin errors++; $display("FAIL copy_writes: got writes=%0d bad=%0d want 31/0", nwr, bad); end
    tick();
    checks++; if (ctx !== 2'd1) begin errors++; $display("FAIL copy_ctx: got %0d want 1", ctx); end
    wrong = 0;
    for (int i = 1; i < 32; i++) if (rf[1][i] !== 32'h100 + 32'(i)) wrong++;
    checks++; if (wrong != 0 || rf[1][0] !== 32'h0) begin errors++; $display("FAIL copy_bank1: got %0d wrong regs, x0=%h want 0/0", wrong, rf[1][0]); end
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL copy_banks: got %0d diffs want 0", bank_diffs()); end
  endtask

  task automatic test_ctx_range();
    int lat, nwr;
    logic e;
    do_switch3(2'd2, 1'b0, lat, e, nwr);
    tick();
    checks++; if (lat != 2 || e !== 1'b0 || ctx3 !== 2'd2) begin errors++; $display("FAIL range_ok: got lat=%0d err=%b ctx=%0d want 2/0/2", lat, e, ctx3); end
    do_switch3(2'd3, 1'b1, lat, e, nwr);
    tick();
    checks++; if (lat != 2 || e !== 1'b1 || nwr != 0) begin errors++; $display("FAIL range_err: got lat=%0d err=%b writes=%0d want 2/1/0", lat, e, nwr); end
    checks++; if (ctx3 !== 2'd2) begin errors++; $display("FAIL range_ctx_kept: got %0d want 2", ctx3); end
    do_switch3(2'd2, 1'b1, lat, e, nwr);
    tick();
    checks++; if (lat != 2 || e !== 1'b0 || nwr != 0 || ctx3 !== 2'd2) begin errors++; $display("FAIL range_self: got lat=%0d err=%b writes=%0d ctx=%0d want 2/0/0/2", lat, e, nwr, ctx3); end
  endtask

  task automatic test_random();
    int lat, nwr, bad, pend, wr_cyc, exp_lat;
    logic [1:0] t;
    logic cp, copy_eff;
    logic [4:0] wa;
    logic [31:0] wd;
    for (int b = 0; b < 4; b++)
      for (int i = 1; i < 32; i++) begin
        rf[b][i] = $urandom;
        ref_bank[b][i] = rf[b][i];
      end
    for (int k = 0; k < 10; k++) begin
      t = 2'($urandom_range(0, 3)); cp = 1'($urandom_range(0, 1));
      pend = $urandom_range(0, 3);
      wr_cyc = (pend > 0) ? $urandom_range(0, pend) : 0;
      wa = 5'($urandom_range(1, 31)); wd = $urandom;
      if (wr_cyc > 0) ref_bank[exp_ctx][wa] = wd;
      copy_eff = cp && (t != exp_ctx);
      if (copy_eff) for (int i = 1; i < 32; i++) ref_bank[t][i] = ref_bank[exp_ctx][i];
      exp_lat = 2 + pend + (copy_eff ? 31 : 0);
      do_switch(t, cp, pend, wr_cyc, wa, wd, lat, nwr, bad);
      exp_ctx = t;
      checks++;
      if (lat != exp_lat || nwr != (copy_eff ? 31 : 0) || bad != 0)
        begin errors++; $display("FAIL rand%0d_switch: got lat=%0d writes=%0d bad=%0d want %0d/%0d/0", k, lat, nwr, bad, exp_lat, copy_eff ? 31 : 0); end
      tick();
      checks++; if (ctx !== exp_ctx) begin errors++; $display("FAIL rand%0d_ctx: got %0d want %0d", k, ctx, exp_ctx); end
      checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL rand%0d_banks: got %0d diffs want 0", k, bank_diffs()); end
    end
  endtask

  task automatic test_reset_mid_copy();
    int lat, nwr, bad, cyc;
    logic found;
    if (exp_ctx != 2'd0) begin
      do_switch(2'd0, 1'b0, 0, 0, 5'd0, 32'h0, lat, nwr, bad);
      exp_ctx = 2'd0;
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      rf[3][i] = 32'hBAD0_0000 | 32'(i);
      ref_bank[3][i] = rf[3][i];
    end
    req = 1'b1; sw_ctx = 2'd3; sw_copy = 1'b1;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 60) begin
      tick();
      cyc++;
      #1;
      if (rf_we && rf_waddr == 5'd10) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midcopy_reach: got no write to x10 in %0d cycles want one", cyc); end
    req = 1'b0; sw_copy = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctx !== 2'd0 || stall !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rf_we !== 1'b0 || rf_rsel !== 2'd0 || rf_wsel !== 2'd0)
      begin errors++; $display("FAIL midcopy_reset: got ctx=%0d stall=%b done=%b err=%b we=%b sel=%0d/%0d want all 0",
                              ctx, stall, done, err, rf_we, rf_rsel, rf_wsel); end
    tick();
    checks++; if (ctx !== 2'd0 || stall !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL midcopy_edge: got ctx=%0d stall=%b we=%b want 0/0/0", ctx, stall, rf_we); end
    rst_n = 1'b1;
    exp_ctx = 2'd0;
    for (int i = 1; i < 10; i++) ref_bank[3][i] = ref_bank[0][i];
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL midcopy_partial: got %0d diffs want 0", bank_diffs()); end
  endtask

  initial begin
    req = 1'b0; sw_ctx = '0; sw_copy = 1'b0; wb_pending = 1'b0;
    core_raddr = '0; core_waddr = '0; core_wdata = '0; core_we = 1'b0;
    req3 = 1'b0; sw_ctx3 = '0; sw_copy3 = 1'b0;
    zero1 = 1'b0; zero5 = '0; zero32 = '0;
    exp_ctx = 2'd0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 32; i++) begin
        rf[b][i] = (i == 0) ? 32'h0 : (32'hB000_0000 | (32'(b) << 8) | 32'(i));
        ref_bank[b][i] = rf[b][i];
      end
    test_reset();
    test_passthrough();
    test_drain();
    test_switch_nocopy();
    test_copy();
    test_ctx_range();
    test_random();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_rf_ctx_ctrl.md
# ibex_rf_ctx_ctrl

Register-file context controller sitting between the ID/WB stages and the multi-bank register file (NumRegFiles banks). It owns the active bank index, accepts context-switch requests, waits for in-flight writebacks to drain, and optionally copies x1..xN from the current bank into the target bank by stealing the register file's A read port and write port. Outside a switch, core register-file traffic passes straight through.

## Interface
- NumRegFiles, 4: number of register banks (≥1); CtxW = max(1, $clog2(NumRegFiles)).
- RV32E, 0: 1 → copy x1..x15; 0 → copy x1..x31.
- DataWidth, 32: register width.

- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- switch_req_i  in  1  switch request; held until switch_done_o.
- switch_ctx_i  in  CtxW  target bank, sampled on accept.
- switch_copy_i  in  1  copy current bank into target, sampled on accept.
- wb_pending_i  in  1  core has a register write in flight.
- switch_done_o  out  1  one-cycle completion pulse.
- switch_err_o  out  1  with done: target out of range, no change.
- stall_o  out  1  core must not issue new instructions.
- ctx_o  out  CtxW  active bank.
- core_raddr_a_i  in  5 / core_waddr_a_i  in  5 / core_wdata_a_i  in  DataWidth / core_we_a_i  in  1  core port A read address and write port.
- rf_raddr_a_o  out  5 / rf_waddr_a_o  out  5 / rf_wdata_a_o  out  DataWidth / rf_we_a_o  out  1  to register file.
- rf_rdata_a_i  in  DataWidth  register file port A read data (port B and rdata to core wired directly, not through this block).
- rf_rsel_o  out  CtxW  bank for reads; rf_wsel_o  out  CtxW  bank for writes (zero-extended to the 32-bit bank select at top level).

## Operation
- States: IDLE, DRAIN, COPY, COMMIT.
- IDLE: pass-through of core port signals; rf_rsel_o = rf_wsel_o = ctx_o. switch_req_i high → accept: latch tgt, copy flag; → DRAIN.
- Copy flag cleared on accept if tgt == ctx_o or tgt ≥ NumRegFiles.
- DRAIN: still pass-through (pending writeback lands in current bank). Exit when wb_pending_i == 0 and core_we_a_i == 0 in same cycle: copy flag → COPY (cnt = 1), else → COMMIT.
- COPY: core port A inputs ignored; rf_raddr_a_o = rf_waddr_a_o = cnt, rf_wdata_a_o = rf_rdata_a_i, rf_we_a_o = 1, rf_rsel_o = ctx_o, rf_wsel_o = tgt. cnt increments each cycle; after cnt == Last (31, or 15 if RV32E) → COMMIT. x0 never written.
- COMMIT: switch_done_o = 1; ctx_o ← tgt at cycle end unless tgt ≥ NumRegFiles (then switch_err_o = 1, ctx_o unchanged); → IDLE. rf_we_a_o = 0.
- stall_o = (state != IDLE).
- Requester drops switch_req_i the cycle after done; req still high in IDLE is a new request.
- NumRegFiles == 1: every switch is no-copy; ctx_o stays 0.

## Timing
- Reset: state IDLE, ctx_o = 0, cnt = 0, tgt = 0; switch_done_o, switch_err_o, stall_o, rf_we_a_o = 0; rf_rsel_o = rf_wsel_o = 0.
- Accept cycle (IDLE, req) = cycle 0; stall_o rises cycle 1.
- No copy, nothing pending: DRAIN c1, COMMIT/done c2, IDLE c3 with new ctx_o.
- Copy, RV32I, nothing pending: DRAIN c1, COPY c2..c32 (31 writes), done c33. RV32E: done c17.
- Each cycle wb_pending_i/core_we_a_i high in DRAIN extends latency by one.
- Reset mid-copy aborts: ctx_o = 0, target bank left partially written.

## Test plan
- Reset, then core_we_a_i=1, waddr=5, wdata=0xDEAD in IDLE → rf_we_a_o=1, waddr 5, rf_wsel_o=0, stall_o=0.
- req, ctx=2, copy=0, no pending → done at c2, ctx_o=2 at c3, rf_we_a_o never asserted by block.
- Bank0 x1..x31 = 0x100+i; req ctx=1, copy=1 → 31 writes, addr 1..31, rf_rsel_o=0, rf_wsel_o=1, done c33; bank1 xi = 0x100+i, x0 = 0.
- wb_pending_i high for 3 cycles after accept → DRAIN held, core write passes to bank 0, done at c5 (no copy).
- NumRegFiles=3, req ctx=3 → done and err at c2, ctx_o unchanged; req ctx == ctx_o with copy=1 → no copy, done c2.
- Assert rst_ni low at COPY cnt=10 → all outputs reset values next edge, ctx_o=0, stall_o=0.
